// File: rtl/player_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// game_pkg / player_motion_ctrl_if : shared game types and motion-engine bus
// Revision: 1.0
// ============================================================================
package game_pkg;
  typedef enum logic [1:0] {
    START       = 2'd0,
    GAME        = 2'd1,
    PLAYER1_WIN = 2'd2,
    PLAYER2_WIN = 2'd3
  } game_mode_t;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;
endpackage

interface player_motion_ctrl_if;
  import game_pkg::*;

  game_mode_t  mode;
  logic        key_up;
  logic        key_down;
  logic        key_left;
  logic        key_right;
  logic        trail_hit;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  dir_t        direction;
  logic        step_valid;
  logic        player1_collision;

  modport master (
    output mode, key_up, key_down, key_left, key_right, trail_hit,
    input  pos_x, pos_y, direction, step_valid, player1_collision
  );

  modport slave (
    input  mode, key_up, key_down, key_left, key_right, trail_hit,
    output pos_x, pos_y, direction, step_valid, player1_collision
  );
endinterface
`default_nettype wire

// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// player_motion_ctrl : steps the player head while in GAME, flags wall/trail hits
// Revision: 1.0
// ============================================================================
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter logic [11:0] START_X   = 12'd100,
  parameter logic [11:0] START_Y   = 12'd384,
  parameter dir_t        START_DIR = RIGHT,
  parameter int          STEP_DIV  = 650_000,
  parameter logic [11:0] STEP      = 12'd1,
  parameter logic [11:0] X_MIN     = 12'd0,
  parameter logic [11:0] X_MAX     = 12'd1023,
  parameter logic [11:0] Y_MIN     = 12'd0,
  parameter logic [11:0] Y_MAX     = 12'd767
) (
  input  logic                 clk,
  input  logic                 rst_n,
  player_motion_ctrl_if.slave  bus
);

  localparam int                    TICK_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(STEP_DIV - 1);
  localparam logic signed [12:0]    STEP_S    = $signed({1'b0, STEP});

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CRASHED = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [11:0]       pos_x, pos_y, next_x, next_y;
  dir_t              direction, next_dir;
  dir_t              pending, next_pend;
  logic [TICK_W-1:0] tick, next_tick;
  logic              step_valid, next_sv;
  logic              collision, next_coll;

  dir_t              key_sel, latched_pend, step_dir;
  logic signed [12:0] cand_x, cand_y;
  logic              out_of_bounds;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return WAIT;
    endcase
  endfunction

  // Key this clk counts toward a step taken on this same clk.
  always_comb begin
    key_sel = WAIT;
    if (bus.key_up)         key_sel = UP;
    else if (bus.key_down)  key_sel = DOWN;
    else if (bus.key_left)  key_sel = LEFT;
    else if (bus.key_right) key_sel = RIGHT;

    latched_pend = pending;
    if (key_sel != WAIT && key_sel != opposite(direction))
      latched_pend = key_sel;

    step_dir = (latched_pend != WAIT) ? latched_pend : direction;

    cand_x = $signed({1'b0, pos_x});
    cand_y = $signed({1'b0, pos_y});
    case (step_dir)
      UP:      cand_y = cand_y - STEP_S;
      DOWN:    cand_y = cand_y + STEP_S;
      LEFT:    cand_x = cand_x - STEP_S;
      RIGHT:   cand_x = cand_x + STEP_S;
      default: ;
    endcase

    out_of_bounds = (cand_x < $signed({1'b0, X_MIN})) || (cand_x > $signed({1'b0, X_MAX})) ||
                    (cand_y < $signed({1'b0, Y_MIN})) || (cand_y > $signed({1'b0, Y_MAX}));
  end

  always_comb begin
    next_state = state;
    next_x     = pos_x;
    next_y     = pos_y;
    next_dir   = direction;
    next_pend  = pending;
    next_tick  = tick;
    next_sv    = 1'b0;
    next_coll  = collision;

    case (state)
      IDLE: begin
        if (bus.mode == GAME) begin
          next_state = RUN;
          next_dir   = START_DIR;
          next_tick  = '0;
        end
      end

      RUN: begin
        if (bus.mode != GAME) begin
          next_state = IDLE;
          next_x     = START_X;
          next_y     = START_Y;
          next_dir   = WAIT;
          next_pend  = WAIT;
          next_tick  = '0;
          next_coll  = 1'b0;
        end else if (bus.trail_hit) begin
          // A trail hit beats a coincident step: the head does not move.
          next_state = CRASHED;
          next_coll  = 1'b1;
        end else if (tick == TICK_LAST) begin
          next_tick = '0;
          next_pend = WAIT;
          if (out_of_bounds) begin
            next_state = CRASHED;
            next_coll  = 1'b1;
          end else begin
            next_x   = cand_x[11:0];
            next_y   = cand_y[11:0];
            next_dir = step_dir;
            next_sv  = 1'b1;
          end
        end else begin
          next_pend = latched_pend;
          next_tick = tick + 1'b1;
        end
      end

      CRASHED: begin
        if (bus.mode != GAME) begin
          next_state = IDLE;
          next_x     = START_X;
          next_y     = START_Y;
          next_dir   = WAIT;
          next_pend  = WAIT;
          next_tick  = '0;
          next_coll  = 1'b0;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos_x      <= START_X;
      pos_y      <= START_Y;
      direction  <= WAIT;
      pending    <= WAIT;
      tick       <= '0;
      step_valid <= 1'b0;
      collision  <= 1'b0;
    end else begin
      state      <= next_state;
      pos_x      <= next_x;
      pos_y      <= next_y;
      direction  <= next_dir;
      pending    <= next_pend;
      tick       <= next_tick;
      step_valid <= next_sv;
      collision  <= next_coll;
    end
  end

  assign bus.pos_x             = pos_x;
  assign bus.pos_y             = pos_y;
  assign bus.direction         = direction;
  assign bus.step_valid        = step_valid;
  assign bus.player1_collision = collision;

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// tb_player_motion_ctrl : randomized bench against a behavioural motion model
// Revision: 1.0
// ============================================================================
module tb_player_motion_ctrl;
  import game_pkg::*;

  localparam logic [28:0] RESET_VEC = {12'd100, 12'd384, WAIT, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  player_motion_ctrl_if bus();

  player_motion_ctrl #(.STEP_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cmp_count  = 0;
  int fail_count = 0;

  // Behavioural model: head position in plain integers, moves as unit vectors.
  int   m_st;   // 0 idle, 1 running, 2 crashed
  int   m_x, m_y, m_cnt;
  dir_t m_dir, m_pend;
  bit   m_sv, m_coll;

  int   dx  [5] = '{0, 0, 0, -1, 1};
  int   dy  [5] = '{0, -1, 1, 0, 0};
  dir_t opp [5] = '{WAIT, DOWN, UP, RIGHT, LEFT};

  function automatic logic [28:0] model_vec();
    return {m_x[11:0], m_y[11:0], m_dir, m_sv, m_coll};
  endfunction

  function automatic logic [28:0] act_vec();
    return {bus.pos_x, bus.pos_y, bus.direction, bus.step_valid, bus.player1_collision};
  endfunction

  task automatic model_reset();
    m_st = 0; m_x = 100; m_y = 384; m_cnt = 0;
    m_dir = WAIT; m_pend = WAIT; m_sv = 0; m_coll = 0;
  endtask

  task automatic model_step();
    dir_t key, d;
    int nx, ny;
    m_sv = 0;
    key = bus.key_up ? UP : bus.key_down ? DOWN : bus.key_left ? LEFT : bus.key_right ? RIGHT : WAIT;
    if (m_st == 0) begin
      if (bus.mode == GAME) begin m_st = 1; m_dir = RIGHT; m_cnt = 0; end
    end else if (bus.mode != GAME) begin
      model_reset();
    end else if (m_st == 1) begin
      if (key != WAIT && key != opp[m_dir]) m_pend = key;
      if (bus.trail_hit) begin
        m_st = 2; m_coll = 1;
      end else begin
        m_cnt++;
        if (m_cnt == 4) begin
          m_cnt = 0;
          d = (m_pend != WAIT) ? m_pend : m_dir;
          m_pend = WAIT;
          nx = m_x + dx[d];
          ny = m_y + dy[d];
          if (nx < 0 || nx > 1023 || ny < 0 || ny > 767) begin
            m_st = 2; m_coll = 1;
          end else begin
            m_x = nx; m_y = ny; m_dir = d; m_sv = 1;
          end
        end
      end
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic set_keys(input bit u, input bit d, input bit l, input bit r);
    bus.key_up = u; bus.key_down = d; bus.key_left = l; bus.key_right = r;
  endtask

  task automatic test_reset();
    bus.mode = START; bus.trail_hit = 1'b0; set_keys(0, 0, 0, 0);
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    cmp_count++;
    if (act_vec() !== RESET_VEC) begin
      fail_count++; $display("FAIL reset actual=%h required=%h", act_vec(), RESET_VEC);
    end
    @(negedge clk);
    clk_cycle();
    rst_n = 1'b1;
    clk_cycle();
  endtask

  task automatic test_steps();
    int pulses = 0;
    bus.mode = GAME;
    for (int i = 0; i < 13; i++) begin
      clk_cycle();
      if (bus.step_valid === 1'b1) pulses++;
      cmp_count++;
      if (act_vec() !== model_vec()) begin
        fail_count++; $display("FAIL steps cyc=%0d actual=%h required=%h", i, act_vec(), model_vec());
      end
    end
    cmp_count++;
    if (bus.pos_x !== 12'd103 || bus.pos_y !== 12'd384 || pulses != 3) begin
      fail_count++;
      $display("FAIL steps_pos actual=%0d/%0d pulses=%0d required=103/384 pulses=3", bus.pos_x, bus.pos_y, pulses);
    end
  endtask

  task automatic test_no_reverse();
    set_keys(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      clk_cycle();
      cmp_count++;
      if (act_vec() !== model_vec()) begin
        fail_count++; $display("FAIL no_reverse cyc=%0d actual=%h required=%h", i, act_vec(), model_vec());
      end
    end
    cmp_count++;
    if (bus.direction !== RIGHT) begin
      fail_count++; $display("FAIL no_reverse_dir actual=%0d required=%0d", bus.direction, RIGHT);
    end
    set_keys(1, 0, 0, 0);
    clk_cycle();
    set_keys(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) clk_cycle();
    cmp_count++;
    if (bus.direction !== UP || bus.pos_y !== 12'd383 || act_vec() !== model_vec()) begin
      fail_count++; $display("FAIL turn_up actual dir=%0d y=%0d required dir=%0d y=383", bus.direction, bus.pos_y, UP);
    end
  endtask

  task automatic test_key_priority();
    set_keys(0, 0, 0, 1);
    clk_cycle();
    set_keys(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) clk_cycle();
    cmp_count++;
    if (bus.direction !== RIGHT || act_vec() !== model_vec()) begin
      fail_count++; $display("FAIL turn_right actual=%h required=%h", act_vec(), model_vec());
    end
    set_keys(1, 0, 1, 0);
    clk_cycle();
    set_keys(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) clk_cycle();
    cmp_count++;
    if (bus.direction !== UP || act_vec() !== model_vec()) begin
      fail_count++; $display("FAIL priority actual dir=%0d required dir=%0d", bus.direction, UP);
    end
  endtask

  task automatic test_trail_on_step();
    int sx, sy;
    for (int i = 0; i < 8 && m_cnt != 3; i++) begin
      clk_cycle();
      cmp_count++;
      if (act_vec() !== model_vec()) begin
        fail_count++; $display("FAIL trail_align cyc=%0d actual=%h required=%h", i, act_vec(), model_vec());
      end
    end
    sx = m_x; sy = m_y;
    bus.trail_hit = 1'b1;
    clk_cycle();
    bus.trail_hit = 1'b0;
    cmp_count++;
    if (bus.player1_collision !== 1'b1 || bus.step_valid !== 1'b0 ||
        bus.pos_x !== sx[11:0] || bus.pos_y !== sy[11:0]) begin
      fail_count++;
      $display("FAIL trail_step actual coll=%b sv=%b pos=%0d/%0d required coll=1 sv=0 pos=%0d/%0d",
               bus.player1_collision, bus.step_valid, bus.pos_x, bus.pos_y, sx, sy);
    end
    clk_cycle();
    cmp_count++;
    if (bus.player1_collision !== 1'b1 || act_vec() !== model_vec()) begin
      fail_count++; $display("FAIL crashed_hold actual=%h required=%h", act_vec(), model_vec());
    end
    bus.mode = PLAYER2_WIN;
    clk_cycle();
    cmp_count++;
    if (act_vec() !== RESET_VEC) begin
      fail_count++; $display("FAIL leave_game actual=%h required=%h", act_vec(), RESET_VEC);
    end
  endtask

  task automatic test_right_wall();
    int n = 0;
    bus.mode = GAME;
    while (!m_coll && n < 4000) begin
      clk_cycle();
      n++;
      cmp_count++;
      if (act_vec() !== model_vec()) begin
        fail_count++; $display("FAIL wall_run cyc=%0d actual=%h required=%h", n, act_vec(), model_vec());
      end
    end
    cmp_count++;
    if (bus.pos_x !== 12'd1023 || bus.player1_collision !== 1'b1 || bus.step_valid !== 1'b0 || !m_coll) begin
      fail_count++;
      $display("FAIL right_wall actual x=%0d coll=%b sv=%b required x=1023 coll=1 sv=0", bus.pos_x, bus.player1_collision, bus.step_valid);
    end
    bus.mode = START;
    clk_cycle();
  endtask

  task automatic test_idle_keys();
    int bad = 0;
    bus.mode = START;
    for (int i = 0; i < 20; i++) begin
      set_keys(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      clk_cycle();
      if (act_vec() !== RESET_VEC) bad++;
    end
    set_keys(0, 0, 0, 0);
    cmp_count++;
    if (bad != 0) begin
      fail_count++; $display("FAIL idle_keys actual bad_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_async_reset();
    bus.mode = GAME;
    for (int i = 0; i < 10; i++) begin
      set_keys(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      clk_cycle();
    end
    cmp_count++;
    if (act_vec() !== model_vec()) begin
      fail_count++; $display("FAIL pre_reset actual=%h required=%h", act_vec(), model_vec());
    end
    rst_n = 1'b0;
    #1;
    cmp_count++;
    if (act_vec() !== RESET_VEC) begin
      fail_count++; $display("FAIL async_reset actual=%h required=%h", act_vec(), RESET_VEC);
    end
    bus.mode = START;
    set_keys(0, 0, 0, 0);
    clk_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.mode = ($urandom_range(0, 99) < 97) ? GAME : game_mode_t'($urandom_range(0, 3));
      bus.trail_hit = ($urandom_range(0, 299) == 0);
      set_keys($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      clk_cycle();
      cmp_count++;
      if (act_vec() !== model_vec()) begin
        fail_count++; $display("FAIL random cyc=%0d actual=%h required=%h", i, act_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_steps();
    test_no_reverse();
    test_key_priority();
    test_trail_on_step();
    test_right_wall();
    test_idle_keys();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
`default_nettype wire
